// File: rtl/lsl_seq.sv
// lsl_seq: sequential logical-shift-left unit.
// A 16-bit operand and a 4-bit amount are captured on start. The operand is then
// shifted left one bit per clock, and done pulses for one cycle when Y and C are
// valid.
// Optional feature macro: LSL_ROTATE_EN. It adds the rot input, which turns each
// step into a rotate-left instead of a zero-fill shift.
module lsl_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [CNT_W-1:0] N,
`ifdef LSL_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic             fill;

`ifdef LSL_ROTATE_EN
  logic rot_q;

  // Capture the rotate select with the operand so rot may change mid-operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_q <= 1'b0;
    end else if (state == IDLE && start) begin
      rot_q <= rot;
    end
  end

  assign fill = rot_q ? Y[WIDTH-1] : 1'b0;
`else
  assign fill = 1'b0;
`endif

  // State register; reset discards any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode. The count is at least 1 whenever SHIFT is entered.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (N == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (count == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on an accepted start, shift one bit per SHIFT cycle, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y     <= '0;
      C     <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            Y     <= A;
            count <= N;
            C     <= 1'b0;
          end
        end
        SHIFT: begin
          C     <= Y[WIDTH-1];
          Y     <= {Y[WIDTH-2:0], fill};
          count <= count - CNT_W'(1);
        end
        default: begin
          // DONE: Y and C hold until the next accepted start.
        end
      endcase
    end
  end

  // Status outputs decode the state register directly, so they are glitch-free and exclusive.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_lsl_seq.sv
// Self-checking bench for lsl_seq.
// A table of vectors feeds a scoreboard queue, and expected results are popped when done
// pulses. Hand-written sequences cover ignored starts, reset mid-shift and rotate mode.
module tb_lsl_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [3:0]  N;
  logic        rot;
  logic [15:0] Y;
  logic        C;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [3:0]  n;
    logic        r;
    logic [15:0] y;
    logic        c;
  } vec_t;

  typedef struct {
    logic [15:0] y;
    logic        c;
    int          n;
  } exp_t;

  exp_t sb[$];

  lsl_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .N     (N),
`ifdef LSL_ROTATE_EN
    .rot   (rot),
`endif
    .Y     (Y),
    .C     (C),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Closed-form reference. The operand is widened to 32 bits and shifted by n in one step.
  // Bit 16 of the widened value is the last bit to leave Y[15], and the upper half is the
  // part that wraps around when rotating.
  function automatic exp_t model(input logic [15:0] a, input logic [3:0] n, input logic r);
    exp_t        e;
    logic [31:0] w;
    w   = {16'h0000, a} << n;
    e.y = r ? (w[15:0] | w[31:16]) : w[15:0];
    e.c = (n == 4'd0) ? 1'b0 : w[16];
    e.n = int'(n);
    return e;
  endfunction

  // Start one operation and wait (bounded) for done. Then check the latency, the number of
  // busy cycles, the result from the scoreboard, and that the result holds one cycle later.
  task automatic run_op(input logic [15:0] a, input logic [3:0] n, input logic r, input string tag);
    exp_t e;
    int   cyc;
    int   bcnt;
    logic seen;
    logic overlap;
    @(negedge clk);
    start = 1'b1;
    A     = a;
    N     = n;
    rot   = r;
    sb.push_back(model(a, n, rot));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A     = 16'($urandom);
    N     = 4'($urandom);
    cyc     = 0;
    bcnt    = 0;
    seen    = 1'b0;
    overlap = 1'b0;
    while (cyc < 40) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_done_excl"}, 32'(overlap), 32'd0);
    e = sb.pop_front();
    check({tag, "_latency"}, 32'(cyc), 32'(e.n));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(e.n));
    check({tag, "_Y"}, 32'(Y), 32'(e.y));
    check({tag, "_C"}, 32'(C), 32'(e.c));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_Y_hold"}, 32'(Y), 32'(e.y));
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    exp_t e;
    int   cyc;

    // Directed table. The expected values are written by hand from the shift definition.
    vecs.push_back('{16'h0001, 4'd4,  1'b0, 16'h0010, 1'b0});
    vecs.push_back('{16'h8001, 4'd1,  1'b0, 16'h0002, 1'b1});
    vecs.push_back('{16'hBEEF, 4'd0,  1'b0, 16'hBEEF, 1'b0});
    vecs.push_back('{16'hFFFF, 4'd15, 1'b0, 16'h8000, 1'b1});
    vecs.push_back('{16'h00FF, 4'd8,  1'b0, 16'hFF00, 1'b0});
    vecs.push_back('{16'h4000, 4'd2,  1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h1234, 4'd3,  1'b0, 16'h91A0, 1'b0});

    rst   = 1'b1;
    start = 1'b0;
    A     = 16'h0;
    N     = 4'h0;
    rot   = 1'b0;
    #12;
    check("reset_Y", 32'(Y), 32'h0);
    check("reset_C", 32'(C), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // The table's own expectations are checked against the model before use.
    foreach (vecs[i]) begin
      e = model(vecs[i].a, vecs[i].n, vecs[i].r);
      check($sformatf("tbl%0d_model_y", i), 32'(e.y), 32'(vecs[i].y));
      check($sformatf("tbl%0d_model_c", i), 32'(e.c), 32'(vecs[i].c));
    end
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_op(v.a, v.n, v.r, $sformatf("tbl%0d", i));
    end

    // Random operands, with expectations taken from the model.
    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom), 4'($urandom), 1'b0, $sformatf("rnd%0d", i));
    end

    // Raise start while busy and during DONE; both starts must be ignored.
    @(negedge clk);
    start = 1'b1;
    A     = 16'h00F0;
    N     = 4'd3;
    @(posedge clk);
    @(negedge clk);
    A   = 16'h1234;
    N   = 4'd5;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_latency", 32'(cyc), 32'd3);
    check("ign_done_with_start", 32'(done), 32'd1);
    check("ign_Y", 32'(Y), 32'h0780);
    check("ign_C", 32'(C), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("ign_back_idle_busy", 32'(busy), 32'd0);
    check("ign_back_idle_done", 32'(done), 32'd0);
    check("ign_Y_kept", 32'(Y), 32'h0780);
    @(negedge clk);
    check("ign_Y_kept2", 32'(Y), 32'h0780);

    // Assert reset partway through a shift. Y, C, busy and done must clear at once.
    @(negedge clk);
    start = 1'b1;
    A     = 16'hFFFF;
    N     = 4'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    check("mid_C_before_rst", 32'(C), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_Y", 32'(Y), 32'h0);
    check("rst_mid_C", 32'(C), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0003, 4'd2, 1'b0, "after_rst");
    check("after_rst_Y_const", 32'(Y), 32'h000C);

`ifdef LSL_ROTATE_EN
    run_op(16'h8001, 4'd1, 1'b1, "rot1");
    check("rot1_Y_const", 32'(Y), 32'h0003);
    check("rot1_C_const", 32'(C), 32'd1);
    run_op(16'h8001, 4'd1, 1'b0, "rot0");
    check("rot0_Y_const", 32'(Y), 32'h0002);
    check("rot0_C_const", 32'(C), 32'd1);
    for (int i = 0; i < 4; i++) begin
      run_op(16'($urandom), 4'($urandom), 1'b1, $sformatf("rrnd%0d", i));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
